// File: rtl/fir_coeff_loader.sv
// Streams signed FIR coefficients into the filter's positive/negative magnitude banks.
// One RAM write per clock; aborts on bank overflow or beat timeout.
module fir_coeff_loader #(
  parameter int unsigned P_POS_DEPTH = 7,
  parameter int unsigned P_NEG_DEPTH = 5,
  parameter int unsigned P_MAX_COEFF = 12,
  parameter int unsigned P_TIMEOUT   = 63
) (
  input  logic        iClk_12M,
  input  logic        iRsn,
  input  logic        iLoadReq,
  input  logic        iCoeffValid,
  input  logic [15:0] iCoeff,
  input  logic        iCoeffLast,
  output logic        oCoeffReady,
  output logic        oCoeffiUpdateFlag,
  output logic        oCsnRam,
  output logic        oWrnRam,
  output logic [3:0]  oAddrRam_pos,
  output logic [3:0]  oAddrRam_neg,
  output logic [15:0] oWrDtRam,
  output logic [5:0]  oNumOfCoeff,
  output logic        oLoadDone,
  output logic        oLoadErr
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 6;
  localparam int unsigned TW = $clog2(P_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_LOAD, S_FLUSH, S_DONE, S_ABORT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_pos_ptr, w_pos_ptr;
  logic [AW-1:0] r_neg_ptr, w_neg_ptr;
  logic [TW-1:0] r_idle, w_idle;
  logic          r_ready, w_ready;
  logic          r_flag, w_flag;
  logic          r_csn, w_csn;
  logic          r_wrn, w_wrn;
  logic [AW-1:0] r_addr_pos, w_addr_pos;
  logic [AW-1:0] r_addr_neg, w_addr_neg;
  logic [DW-1:0] r_data, w_data;
  logic [CW-1:0] r_num, w_num;
  logic          r_done, w_done;
  logic          r_err, w_err;

  logic          w_accept;
  logic          w_is_neg;
  logic          w_ovf;
  logic          w_abort;
  logic [DW-1:0] w_mag;
  logic [CW-1:0] w_num_inc;

  // Magnitude of a negative beat; the most negative code has no positive twin.
  assign w_is_neg  = iCoeff[DW-1];
  assign w_mag     = (iCoeff == 16'h8000) ? 16'h7FFF : DW'(~iCoeff + 16'd1);
  assign w_accept  = (r_state == S_LOAD) && iCoeffValid && r_ready;
  assign w_ovf     = w_is_neg ? (r_neg_ptr == AW'(P_NEG_DEPTH))
                              : (r_pos_ptr == AW'(P_POS_DEPTH));
  assign w_num_inc = r_num + CW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_pos_ptr   = r_pos_ptr;
    w_neg_ptr   = r_neg_ptr;
    w_idle      = r_idle;
    w_ready     = 1'b0;
    w_flag      = r_flag;
    w_csn       = 1'b1;
    w_wrn       = 1'b1;
    w_addr_pos  = '0;
    w_addr_neg  = '0;
    w_data      = '0;
    w_num       = r_num;
    w_done      = 1'b0;
    w_err       = r_err;
    w_abort     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (iLoadReq) begin
          w_state_nxt = S_PREP;
          w_err       = 1'b0;
          w_num       = '0;
          w_pos_ptr   = '0;
          w_neg_ptr   = '0;
          w_idle      = '0;
          w_flag      = 1'b1;
          w_csn       = 1'b0;
          w_wrn       = 1'b0;
        end
      end
      S_PREP: begin
        w_state_nxt = S_LOAD;
        w_ready     = 1'b1;
        w_csn       = 1'b0;
        w_wrn       = 1'b0;
      end
      S_LOAD: begin
        w_ready = 1'b1;
        w_csn   = 1'b0;
        w_wrn   = 1'b0;
        if (w_accept) begin
          w_idle = '0;
          if (w_ovf) begin
            w_abort = 1'b1;
          end else begin
            w_num = w_num_inc;
            if (w_is_neg) begin
              w_neg_ptr  = r_neg_ptr + AW'(1);
              w_addr_neg = r_neg_ptr + AW'(1);
              w_data     = w_mag;
            end else begin
              w_pos_ptr  = r_pos_ptr + AW'(1);
              w_addr_pos = r_pos_ptr + AW'(1);
              w_data     = iCoeff;
            end
            if (iCoeffLast || (w_num_inc == CW'(P_MAX_COEFF))) begin
              w_state_nxt = S_FLUSH;
              w_ready     = 1'b0;
            end
          end
        end else if (r_idle == TW'(P_TIMEOUT - 1)) begin
          w_abort = 1'b1;
        end else begin
          w_idle = r_idle + TW'(1);
        end
      end
      S_FLUSH: begin
        w_state_nxt = S_DONE;
        w_flag      = 1'b0;
        w_done      = 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ABORT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // Abort overrides any write or completion decided above.
    if (w_abort) begin
      w_state_nxt = S_ABORT;
      w_err       = 1'b1;
      w_ready     = 1'b0;
      w_flag      = 1'b0;
      w_csn       = 1'b1;
      w_wrn       = 1'b1;
      w_num       = '0;
      w_addr_pos  = '0;
      w_addr_neg  = '0;
      w_data      = '0;
    end
  end

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      r_state    <= S_IDLE;
      r_pos_ptr  <= '0;
      r_neg_ptr  <= '0;
      r_idle     <= '0;
      r_ready    <= 1'b0;
      r_flag     <= 1'b0;
      r_csn      <= 1'b1;
      r_wrn      <= 1'b1;
      r_addr_pos <= '0;
      r_addr_neg <= '0;
      r_data     <= '0;
      r_num      <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pos_ptr  <= w_pos_ptr;
      r_neg_ptr  <= w_neg_ptr;
      r_idle     <= w_idle;
      r_ready    <= w_ready;
      r_flag     <= w_flag;
      r_csn      <= w_csn;
      r_wrn      <= w_wrn;
      r_addr_pos <= w_addr_pos;
      r_addr_neg <= w_addr_neg;
      r_data     <= w_data;
      r_num      <= w_num;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  assign oCoeffReady       = r_ready;
  assign oCoeffiUpdateFlag = r_flag;
  assign oCsnRam           = r_csn;
  assign oWrnRam           = r_wrn;
  assign oAddrRam_pos      = r_addr_pos;
  assign oAddrRam_neg      = r_addr_neg;
  assign oWrDtRam          = r_data;
  assign oNumOfCoeff       = r_num;
  assign oLoadDone         = r_done;
  assign oLoadErr          = r_err;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed self-checking bench for fir_coeff_loader: table-driven loads plus abort/reset corners.
module tb_fir_coeff_loader;

  logic        clk;
  logic        rst_n;
  logic        iLoadReq;
  logic        iCoeffValid;
  logic [15:0] iCoeff;
  logic        iCoeffLast;
  logic        oCoeffReady;
  logic        oCoeffiUpdateFlag;
  logic        oCsnRam;
  logic        oWrnRam;
  logic [3:0]  oAddrRam_pos;
  logic [3:0]  oAddrRam_neg;
  logic [15:0] oWrDtRam;
  logic [5:0]  oNumOfCoeff;
  logic        oLoadDone;
  logic        oLoadErr;

  fir_coeff_loader dut (
    .iClk_12M          (clk),
    .iRsn              (rst_n),
    .iLoadReq          (iLoadReq),
    .iCoeffValid       (iCoeffValid),
    .iCoeff            (iCoeff),
    .iCoeffLast        (iCoeffLast),
    .oCoeffReady       (oCoeffReady),
    .oCoeffiUpdateFlag (oCoeffiUpdateFlag),
    .oCsnRam           (oCsnRam),
    .oWrnRam           (oWrnRam),
    .oAddrRam_pos      (oAddrRam_pos),
    .oAddrRam_neg      (oAddrRam_neg),
    .oWrDtRam          (oWrDtRam),
    .oNumOfCoeff       (oNumOfCoeff),
    .oLoadDone         (oLoadDone),
    .oLoadErr          (oLoadErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] coeff;
    logic [3:0]  pos;
    logic [3:0]  neg;
    logic [15:0] data;
  } vec_t;

  vec_t nom[12];
  int   n_chk;
  int   n_pass;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, 32'(oCoeffReady), 32'd0);
    chk({tag, "_flag"},  32'(oCoeffiUpdateFlag), 32'd0);
    chk({tag, "_csn"},   32'(oCsnRam), 32'd1);
    chk({tag, "_wrn"},   32'(oWrnRam), 32'd1);
    chk({tag, "_apos"},  32'(oAddrRam_pos), 32'd0);
    chk({tag, "_aneg"},  32'(oAddrRam_neg), 32'd0);
    chk({tag, "_data"},  32'(oWrDtRam), 32'd0);
    chk({tag, "_done"},  32'(oLoadDone), 32'd0);
  endtask

  // Request pulse, then check the PREP cycle and arrival in LOAD.
  task automatic start_load();
    iLoadReq = 1'b1;
    tick();
    iLoadReq = 1'b0;
    chk("prep_flag", 32'(oCoeffiUpdateFlag), 32'd1);
    chk("prep_csn",  32'(oCsnRam), 32'd0);
    chk("prep_wrn",  32'(oWrnRam), 32'd0);
    chk("prep_err",  32'(oLoadErr), 32'd0);
    chk("prep_num",  32'(oNumOfCoeff), 32'd0);
    chk("prep_ready", 32'(oCoeffReady), 32'd0);
    tick();
    chk("load_ready", 32'(oCoeffReady), 32'd1);
  endtask

  task automatic beat(input logic [15:0] c, input logic last);
    chk("beat_ready", 32'(oCoeffReady), 32'd1);
    iCoeffValid = 1'b1;
    iCoeff      = c;
    iCoeffLast  = last;
    tick();
    iCoeffValid = 1'b0;
    iCoeffLast  = 1'b0;
    iCoeff      = 16'h0;
  endtask

  task automatic chk_write(input string tag, input vec_t v, input int cnt);
    chk({tag, "_apos"}, 32'(oAddrRam_pos), 32'(v.pos));
    chk({tag, "_aneg"}, 32'(oAddrRam_neg), 32'(v.neg));
    chk({tag, "_data"}, 32'(oWrDtRam), 32'(v.data));
    chk({tag, "_num"},  32'(oNumOfCoeff), 32'(cnt));
    chk({tag, "_csn"},  32'(oCsnRam), 32'd0);
  endtask

  task automatic finish_ok(input int cnt);
    chk("flush_ready", 32'(oCoeffReady), 32'd0);
    chk("flush_flag",  32'(oCoeffiUpdateFlag), 32'd1);
    tick();
    chk("done_pulse", 32'(oLoadDone), 32'd1);
    chk("done_flag",  32'(oCoeffiUpdateFlag), 32'd0);
    chk("done_csn",   32'(oCsnRam), 32'd1);
    chk("done_wrn",   32'(oWrnRam), 32'd1);
    chk("done_apos",  32'(oAddrRam_pos), 32'd0);
    chk("done_num",   32'(oNumOfCoeff), 32'(cnt));
    chk("done_err",   32'(oLoadErr), 32'd0);
    tick();
    chk("post_done", 32'(oLoadDone), 32'd0);
    chk("post_num",  32'(oNumOfCoeff), 32'(cnt));
  endtask

  task automatic nominal_load(input logic gapped);
    start_load();
    for (int i = 0; i < 12; i++) begin
      beat(nom[i].coeff, (i == 11));
      chk_write(gapped ? "gap_wr" : "nom_wr", nom[i], i + 1);
      if (gapped && i != 11) begin
        tick();
        chk("gap_apos", 32'(oAddrRam_pos), 32'd0);
        chk("gap_aneg", 32'(oAddrRam_neg), 32'd0);
        chk("gap_data", 32'(oWrDtRam), 32'd0);
      end
    end
    finish_ok(12);
  endtask

  initial begin
    nom[0]  = '{16'd3,      4'd1, 4'd0, 16'd3};
    nom[1]  = '{-16'sd6,    4'd0, 4'd1, 16'd6};
    nom[2]  = '{16'd7,      4'd2, 4'd0, 16'd7};
    nom[3]  = '{-16'sd11,   4'd0, 4'd2, 16'd11};
    nom[4]  = '{16'd13,     4'd3, 4'd0, 16'd13};
    nom[5]  = '{-16'sd19,   4'd0, 4'd3, 16'd19};
    nom[6]  = '{16'd24,     4'd4, 4'd0, 16'd24};
    nom[7]  = '{-16'sd37,   4'd0, 4'd4, 16'd37};
    nom[8]  = '{16'd48,     4'd5, 4'd0, 16'd48};
    nom[9]  = '{-16'sd102,  4'd0, 4'd5, 16'd102};
    nom[10] = '{16'd206,    4'd6, 4'd0, 16'd206};
    nom[11] = '{16'd500,    4'd7, 4'd0, 16'd500};

    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    iLoadReq = 1'b0;
    iCoeffValid = 1'b0;
    iCoeff = 16'h0;
    iCoeffLast = 1'b0;
    tick();
    tick();
    chk_idle_outputs("rst");
    chk("rst_num", 32'(oNumOfCoeff), 32'd0);
    chk("rst_err", 32'(oLoadErr), 32'd0);
    rst_n = 1'b1;
    tick();

    // Valid beats in IDLE must be ignored.
    iCoeffValid = 1'b1;
    iCoeff = 16'd5;
    tick();
    iCoeffValid = 1'b0;
    chk("idle_ign_apos", 32'(oAddrRam_pos), 32'd0);
    chk("idle_ign_num",  32'(oNumOfCoeff), 32'd0);

    nominal_load(1'b0);
    nominal_load(1'b1);

    // Overflow: sixth negative beat exceeds the negative bank.
    start_load();
    for (int i = 0; i < 5; i++) begin
      beat(16'hFFFF, 1'b0);
      chk("ovf_aneg", 32'(oAddrRam_neg), 32'(i + 1));
    end
    beat(16'hFFFF, 1'b1);
    chk("ovf_err",   32'(oLoadErr), 32'd1);
    chk("ovf_num",   32'(oNumOfCoeff), 32'd0);
    chk("ovf_csn",   32'(oCsnRam), 32'd1);
    chk("ovf_aneg0", 32'(oAddrRam_neg), 32'd0);
    chk("ovf_flag",  32'(oCoeffiUpdateFlag), 32'd0);
    chk("ovf_done",  32'(oLoadDone), 32'd0);
    tick();
    chk("ovf_sticky", 32'(oLoadErr), 32'd1);
    chk("ovf_nodone", 32'(oLoadDone), 32'd0);

    // Timeout: two beats then 63 idle LOAD cycles.
    start_load();
    beat(16'd1, 1'b0);
    beat(-16'sd1, 1'b0);
    chk("to_num", 32'(oNumOfCoeff), 32'd2);
    for (int i = 0; i < 62; i++) tick();
    chk("to_early_err",   32'(oLoadErr), 32'd0);
    chk("to_early_ready", 32'(oCoeffReady), 32'd1);
    tick();
    chk("to_err",  32'(oLoadErr), 32'd1);
    chk("to_num0", 32'(oNumOfCoeff), 32'd0);
    chk("to_done", 32'(oLoadDone), 32'd0);
    tick();
    chk("to_nodone", 32'(oLoadDone), 32'd0);

    // Saturation of the most negative code and zero as positive.
    start_load();
    iLoadReq = 1'b1;
    beat(16'h8000, 1'b0);
    iLoadReq = 1'b0;
    chk("sat_aneg", 32'(oAddrRam_neg), 32'd1);
    chk("sat_apos", 32'(oAddrRam_pos), 32'd0);
    chk("sat_data", 32'(oWrDtRam), 32'h7FFF);
    beat(16'h0000, 1'b1);
    chk("zero_apos", 32'(oAddrRam_pos), 32'd1);
    chk("zero_aneg", 32'(oAddrRam_neg), 32'd0);
    chk("zero_data", 32'(oWrDtRam), 32'd0);
    finish_ok(2);

    // Reset mid-load returns outputs immediately, then a clean reload.
    start_load();
    for (int i = 0; i < 4; i++) beat(nom[i].coeff, 1'b0);
    chk("mid_num", 32'(oNumOfCoeff), 32'd4);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    chk("midrst_num", 32'(oNumOfCoeff), 32'd0);
    chk("midrst_err", 32'(oLoadErr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    nominal_load(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
